pll_reset_cen: RTL and testbench
================================

PLL_RESET_CEN -- requirements
Module: pll_reset_cen

Interface
REQ-001 Parameter LOCK_CYCLES, default 1024; consecutive synchronized-lock cycles required before core reset releases (legal range 2..65535).
REQ-002 Parameter RELOCK_W, default 8; width of the relock counter.
REQ-003 clk  in  1  PLL fast output clock, 114.75 MHz; the only clock.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 locked  in  1  raw PLL lock, asynchronous to clk.
REQ-006 soft_rst  in  1  synchronous request to re-run the reset sequence.
REQ-007 clr_lost  in  1  synchronous clear for lost_lock.
REQ-008 core_rst  out  1  active-high reset for core logic; high whenever state is not RUN.
REQ-009 cen_28  out  1  one-cycle enable at clk/4, i.e. 28.6875 MHz.
REQ-010 cen_7  out  1  one-cycle enable at clk/16, phase A.
REQ-011 cen_7_b  out  1  one-cycle enable at clk/16, phase B, offset by 8 cycles from cen_7.
REQ-012 lost_lock  out  1  sticky flag: lock was lost while in RUN.
REQ-013 relock_count  out  RELOCK_W  saturating count of RUN-to-lock-loss events.
REQ-014 state  out  2  current FSM state, for debug.

Function
REQ-015 locked SHALL pass through a 2-flop synchronizer; locked_s is valid 2 clk edges after locked changes.
REQ-016 The FSM SHALL have the states WAIT_LOCK=0, STABLE=1 and RUN=2; encoding 3 is unused and SHALL return to WAIT_LOCK.
REQ-017 In WAIT_LOCK, if locked_s=1, the FSM SHALL go to STABLE with cnt=0.
REQ-018 In STABLE, locked_s=0 SHALL return the FSM to WAIT_LOCK and clear cnt.
REQ-019 In STABLE, if cnt equals LOCK_CYCLES-1, the FSM SHALL enter RUN; otherwise cnt SHALL increment.
REQ-020 In RUN, locked_s=0 SHALL go to WAIT_LOCK, set lost_lock and increment relock_count, which saturates at all-ones.
REQ-021 soft_rst=1 in any state SHALL force WAIT_LOCK on the next edge and clear cnt; alone, it SHALL NOT set lost_lock or count.
REQ-022 If soft_rst and locked_s=0 occur together in RUN, the event SHALL be treated as a lock loss (REQ-020).
REQ-023 lost_lock SHALL be cleared by clr_lost; if set and clear occur in the same cycle, set SHALL win.
REQ-024 core_rst SHALL equal (state != RUN), driven from a registered state with no combinational path from any input.
REQ-025 The phase counter ph[3:0] SHALL be held at 0 outside RUN and increment modulo 16 in RUN; on the first RUN cycle, ph=0.
REQ-026 cen_28 SHALL be 1 when ph[1:0]=3, cen_7 when ph=15, and cen_7_b when ph=7, all gated by RUN; all enables SHALL be 0 outside RUN.
REQ-027 Relative to core_rst falling at cycle T, cen_28 SHALL first pulse at T+3, cen_7_b at T+7 and cen_7 at T+15.
REQ-028 Latency SHALL be exactly LOCK_CYCLES+3 edges from the first clk edge that samples locked=1 until core_rst falls.
REQ-029 Lock loss in RUN SHALL assert core_rst 3 edges after locked falls, and enables SHALL stop in that same cycle.

Reset
REQ-030 While rst=1, all of the following SHALL hold immediately and asynchronously:
- state=WAIT_LOCK, cnt=0, ph=0
- synchronizer flops=0
- core_rst=1, cen_*=0
- lost_lock=0, relock_count=0
REQ-031 Release of rst SHALL follow the normal sequence; rst SHALL NOT count as a lock loss.

Structure
REQ-032 A shared package SHALL hold the state enum (WAIT_LOCK, STABLE, RUN) and the constants PH_CEN28=3, PH_CEN7=15 and PH_CEN7B=7.
REQ-033 The 2-flop synchronizer SHALL be one sub-module, sync_2ff, with async active-high reset; the rest is flat.

Verification (LOCK_CYCLES=16)
REQ-034 Scenario, normal lock:
- Stimulus: rst released, locked raised and held.
- Response: core_rst falls exactly 19 edges after the first edge that samples locked=1; cen_28 first at +3, cen_7_b at +7, cen_7 at +15, then periods 4/16/16.
REQ-035 Scenario, glitch during STABLE: locked drops for 1 cycle at STABLE cnt=10 -> FSM returns to WAIT_LOCK, the count restarts, core_rst stays high, lost_lock=0.
REQ-036 Scenario, lock loss in RUN: locked dropped in RUN -> core_rst=1 and enables=0 after 3 edges; lost_lock=1, relock_count=1; the relock sequence repeats with 19-edge latency.
REQ-037 Scenario, soft_rst and clr_lost:
- soft_rst pulsed in RUN: WAIT_LOCK next edge, lost_lock and relock_count unchanged.
- clr_lost asserted together with a lock loss: lost_lock stays 1.
REQ-038 Scenario, saturation: RELOCK_W=2 with 5 lock losses -> relock_count=3.
REQ-039 Scenario, reset mid-operation: rst asserted mid-STABLE and mid-RUN -> all outputs reach reset values without waiting for a clock edge.

Source files
------------

// File: rtl/pll_reset_cen_pkg.sv
// Shared types and constants for the PLL reset sequencer and clock-enable generator.
package pll_reset_cen_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        STABLE    = 2'd1,
        RUN       = 2'd2
    } state_t;

    localparam logic [3:0] PH_CEN28 = 4'd3;
    localparam logic [3:0] PH_CEN7  = 4'd15;
    localparam logic [3:0] PH_CEN7B = 4'd7;

endpackage

// File: rtl/pll_reset_cen_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level into the clk domain.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_reset_cen.sv
// Holds core logic in reset until the PLL has been locked for LOCK_CYCLES,
// then produces clk/4 and two-phase clk/16 clock enables.
module pll_reset_cen
    import pll_reset_cen_pkg::*;
#(
    parameter int unsigned LOCK_CYCLES = 1024,
    parameter int unsigned RELOCK_W    = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                locked,
    input  logic                soft_rst,
    input  logic                clr_lost,
    output logic                core_rst,
    output logic                cen_28,
    output logic                cen_7,
    output logic                cen_7_b,
    output logic                lost_lock,
    output logic [RELOCK_W-1:0] relock_count,
    output logic [1:0]          state
);

    localparam logic [15:0] CNT_LAST = 16'(LOCK_CYCLES - 1);

    logic        locked_s;
    state_t      state_q;
    state_t      state_d;
    logic [15:0] cnt_q;
    logic [15:0] cnt_d;
    logic [3:0]  ph;
    logic        lock_loss;
    logic        run_q;

    sync_2ff u_sync_2ff (
        .clk (clk),
        .rst (rst),
        .d   (locked),
        .q   (locked_s)
    );

    // A loss in RUN is counted even when soft_rst arrives on the same edge.
    assign lock_loss = (state_q == RUN) && !locked_s;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            WAIT_LOCK: begin
                if (locked_s) begin
                    state_d = STABLE;
                    cnt_d   = '0;
                end
            end
            STABLE: begin
                if (!locked_s) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = RUN;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            RUN: begin
                if (!locked_s) begin
                    state_d = WAIT_LOCK;
                end
            end
            default: begin
                state_d = WAIT_LOCK;
                cnt_d   = '0;
            end
        endcase
        if (soft_rst) begin
            state_d = WAIT_LOCK;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= WAIT_LOCK;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // core_rst is re-registered from state so no input reaches it combinationally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            core_rst <= 1'b1;
        end else begin
            core_rst <= (state_q != RUN);
        end
    end

    assign run_q = !core_rst;

    // Phase starts at 0 on the first cycle core_rst is low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ph <= '0;
        end else if (state_q != RUN) begin
            ph <= '0;
        end else if (run_q) begin
            ph <= ph + 4'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lost_lock    <= 1'b0;
            relock_count <= '0;
        end else begin
            if (lock_loss) begin
                lost_lock <= 1'b1;
            end else if (clr_lost) begin
                lost_lock <= 1'b0;
            end
            if (lock_loss && (relock_count != '1)) begin
                relock_count <= relock_count + RELOCK_W'(1);
            end
        end
    end

    assign cen_28  = run_q && (ph[1:0] == PH_CEN28[1:0]);
    assign cen_7   = run_q && (ph == PH_CEN7);
    assign cen_7_b = run_q && (ph == PH_CEN7B);
    assign state   = state_q;

endmodule

// File: tb/tb_pll_reset_cen.sv
// Directed bench for pll_reset_cen with LOCK_CYCLES=16 and a 2-bit relock counter.
module tb_pll_reset_cen;

    localparam int unsigned LOCK_CYCLES = 16;
    localparam int unsigned RELOCK_W    = 2;

    logic                clk = 1'b0;
    logic                rst;
    logic                locked;
    logic                soft_rst;
    logic                clr_lost;
    logic                core_rst;
    logic                cen_28;
    logic                cen_7;
    logic                cen_7_b;
    logic                lost_lock;
    logic [RELOCK_W-1:0] relock_count;
    logic [1:0]          state;

    int n_checks = 0;
    int n_errors = 0;
    int idx;

    pll_reset_cen #(
        .LOCK_CYCLES (LOCK_CYCLES),
        .RELOCK_W    (RELOCK_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .locked       (locked),
        .soft_rst     (soft_rst),
        .clr_lost     (clr_lost),
        .core_rst     (core_rst),
        .cen_28       (cen_28),
        .cen_7        (cen_7),
        .cen_7_b      (cen_7_b),
        .lost_lock    (lost_lock),
        .relock_count (relock_count),
        .state        (state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Edge index of the first sample where core_rst == lvl; -1 on timeout.
    task automatic wait_core_rst(input logic lvl, input int start, output int at);
        at = -1;
        for (int i = start; i < start + 100; i++) begin
            step(1);
            if (core_rst == lvl) begin
                at = i;
                break;
            end
        end
    endtask

    task automatic check_reset(input string pfx);
        check({pfx, "_state"},     int'(state),        0);
        check({pfx, "_core_rst"},  int'(core_rst),     1);
        check({pfx, "_cen_28"},    int'(cen_28),       0);
        check({pfx, "_cen_7"},     int'(cen_7),        0);
        check({pfx, "_cen_7_b"},   int'(cen_7_b),      0);
        check({pfx, "_lost_lock"}, int'(lost_lock),    0);
        check({pfx, "_relock"},    int'(relock_count), 0);
    endtask

    // Called on the first sample with core_rst low (offset 0).
    task automatic measure_cen(input string pfx);
        int f28  = -1;
        int s28  = -1;
        int f7   = -1;
        int s7   = -1;
        int f7b  = -1;
        int s7b  = -1;
        for (int i = 0; i < 40; i++) begin
            if (cen_28) begin
                if (f28 < 0) f28 = i;
                else if (s28 < 0) s28 = i;
            end
            if (cen_7) begin
                if (f7 < 0) f7 = i;
                else if (s7 < 0) s7 = i;
            end
            if (cen_7_b) begin
                if (f7b < 0) f7b = i;
                else if (s7b < 0) s7b = i;
            end
            step(1);
        end
        check({pfx, "_cen28_first"},  f28,       3);
        check({pfx, "_cen28_period"}, s28 - f28, 4);
        check({pfx, "_cen7b_first"},  f7b,       7);
        check({pfx, "_cen7b_period"}, s7b - f7b, 16);
        check({pfx, "_cen7_first"},   f7,        15);
        check({pfx, "_cen7_period"},  s7 - f7,   16);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst      = 1'b1;
        locked   = 1'b0;
        soft_rst = 1'b0;
        clr_lost = 1'b0;
        #1;
        check_reset("async_por");
        step(3);
        check_reset("por");
        rst = 1'b0;
        step(2);
        check("idle_state", int'(state), 0);
        check("idle_core_rst", int'(core_rst), 1);

        // Normal lock
        locked = 1'b1;
        wait_core_rst(1'b0, 0, idx);
        check("lock_latency", idx, 19);
        check("run_state", int'(state), 2);
        measure_cen("run1");

        // Lock loss in RUN
        locked = 1'b0;
        wait_core_rst(1'b1, 0, idx);
        check("loss_latency", idx, 3);
        check("loss_cen_28", int'(cen_28), 0);
        check("loss_cen_7", int'(cen_7), 0);
        check("loss_cen_7_b", int'(cen_7_b), 0);
        check("loss_state", int'(state), 0);
        check("loss_lost_lock", int'(lost_lock), 1);
        check("loss_relock", int'(relock_count), 1);
        step(3);
        locked = 1'b1;
        wait_core_rst(1'b0, 0, idx);
        check("relock_latency", idx, 19);

        // soft_rst alone in RUN
        step(5);
        soft_rst = 1'b1;
        step(1);
        soft_rst = 1'b0;
        check("soft_state", int'(state), 0);
        check("soft_lost_lock", int'(lost_lock), 1);
        check("soft_relock", int'(relock_count), 1);
        step(1);
        check("soft_core_rst", int'(core_rst), 1);
        wait_core_rst(1'b0, 2, idx);
        check("soft_relock_latency", idx, 18);

        // clr_lost alone clears; with a simultaneous loss the set wins
        step(2);
        clr_lost = 1'b1;
        step(1);
        clr_lost = 1'b0;
        check("clr_lost", int'(lost_lock), 0);
        locked = 1'b0;
        step(2);
        clr_lost = 1'b1;
        step(1);
        clr_lost = 1'b0;
        check("set_wins", int'(lost_lock), 1);
        check("set_wins_relock", int'(relock_count), 2);
        check("set_wins_state", int'(state), 0);
        locked = 1'b1;
        wait_core_rst(1'b0, 0, idx);
        check("relock2_latency", idx, 19);

        // soft_rst coinciding with lock loss counts as a loss
        step(2);
        locked = 1'b0;
        step(2);
        soft_rst = 1'b1;
        step(1);
        soft_rst = 1'b0;
        check("soft_loss_relock", int'(relock_count), 3);
        check("soft_loss_lost_lock", int'(lost_lock), 1);
        check("soft_loss_state", int'(state), 0);

        // Losses four and five: the 2-bit counter holds at 3
        for (int k = 0; k < 2; k++) begin
            locked = 1'b1;
            wait_core_rst(1'b0, 0, idx);
            check("sat_lock_latency", idx, 19);
            step(2);
            locked = 1'b0;
            wait_core_rst(1'b1, 0, idx);
            check("sat_loss_latency", idx, 3);
        end
        check("saturate", int'(relock_count), 3);

        // Reset mid-RUN, applied between edges while cen_28 is high
        locked = 1'b1;
        wait_core_rst(1'b0, 0, idx);
        for (int i = 0; i < 8; i++) begin
            if (cen_28) break;
            step(1);
        end
        check("cen28_before_rst", int'(cen_28), 1);
        #2;
        rst = 1'b1;
        #2;
        check_reset("rst_run");
        #1;
        rst = 1'b0;
        wait_core_rst(1'b0, 0, idx);
        check("post_rst_latency", idx, 19);
        check("post_rst_lost_lock", int'(lost_lock), 0);
        check("post_rst_relock", int'(relock_count), 0);

        // Reset mid-STABLE
        soft_rst = 1'b1;
        step(1);
        soft_rst = 1'b0;
        step(10);
        check("mid_stable_state", int'(state), 1);
        #2;
        rst = 1'b1;
        #2;
        check_reset("rst_stable");
        #1;
        rst = 1'b0;

        // One-cycle glitch seen by the FSM at STABLE cnt=10
        step(11);
        locked = 1'b0;
        step(1);
        locked = 1'b1;
        step(1);
        check("glitch_in_stable", int'(state), 1);
        step(1);
        check("glitch_state", int'(state), 0);
        check("glitch_core_rst", int'(core_rst), 1);
        check("glitch_lost_lock", int'(lost_lock), 0);
        wait_core_rst(1'b0, 2, idx);
        check("glitch_latency", idx, 19);
        check("glitch_relock", int'(relock_count), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
